flags_register: RTL and testbench
=================================

// Module: flags_register
// PURPOSE
//   Consumer side of the ALU flag/bus interface. Latches the 5-bit ALU flag vector,
//   restores it from the data bus, and drives it back onto the bus (PUSHF/POPF).
//   Evaluates branch conditions for the control unit from the registered flags.
//   Holds a small LIFO of saved flag vectors so interrupt entry/exit can save and restore flags.
// PARAMETERS
//   WIDTH        8   data bus width; must be >= 5
//   STACK_DEPTH  4   saved-flag LIFO entries; must be >= 1
// PORTS
//   clk          in   1      system clock; all state changes on the rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   flags_in     in   5      ALU flags {lcarry, acarry, zero, sign, overflow}
//   load_alu     in   1      latch flags_in
//   load_bus     in   1      latch bus_in[4:0]
//   bus_in       in   WIDTH  data bus
//   assert_bus   in   1      request to drive flags onto the bus
//   bus_out      out  WIDTH  {WIDTH-5 zeros, flags}
//   bus_en       out  1      active-low bus drive enable; equals ~assert_bus
//   save         in   1      push current flags onto the LIFO
//   restore      in   1      pop the LIFO into flags
//   cond         in   4      condition code to evaluate
//   cond_true    out  1      condition result, combinational from the flags register
//   flags        out  5      registered flag vector
//   stack_empty  out  1      LIFO holds 0 entries
//   stack_full   out  1      LIFO holds STACK_DEPTH entries
//   stack_err    out  1      sticky push-on-full or pop-on-empty error
// BEHAVIOUR
//   Reset (async assert, takes effect immediately):
//     flags=0, LIFO count=0, stack_empty=1, stack_full=0, stack_err=0.
//     bus_out=0; cond_true = f(cond, 0).
//   Flag-register update priority each edge: restore (pop valid) > load_bus > load_alu > hold.
//   An invalid pop (LIFO empty) falls through to the next-priority source.
//   Latency: one edge. The new flags are visible on flags, bus_out and cond_true after the edge.
//   save + load_alu in the same cycle: the LIFO receives the PRE-edge flags; the register
//     takes flags_in. This is the interrupt-entry case.
//   save + restore in the same cycle: neither performed. The LIFO, count and stack_err are
//     unchanged, and the register follows load_bus/load_alu.
//   Push when full: ignored, stack_err<=1. Pop when empty: ignored, stack_err<=1.
//   stack_err is cleared only by reset.
//   LIFO stores STACK_DEPTH x 5 bits. The count has range 0..STACK_DEPTH. It never wraps.
//   bus_out is driven regardless of assert_bus; bus_en gates the external tri-state.
//   bus_in[WIDTH-1:5] is ignored.
//   Condition codes (Z=zero, C=acarry, L=lcarry, S=sign, O=overflow):
//     0 always   1 Z    2 !Z   3 C    4 !C   5 L    6 !L   7 S
//     8 !S       9 O    10 !O  11 S^O (signed lt)   12 !(S^O) (ge)
//     13 (S^O)|Z (le)   14 !((S^O)|Z) (gt)          15 never
//   Reset asserted mid-operation: any pending load, push or pop is discarded.
// STRUCTURE
//   Shared include alu_flags_defs.v:
//     - flag bit indices: LCARRY=4, ACARRY=3, ZERO=2, SIGN=1, OVERFLOW=0
//     - localparams for the 16 condition codes
//   The ALU and the control unit include the same file.
//   Sub-module flags_stack (DEPTH, 5-bit LIFO: push, pop, dout, empty, full, err).
//   Condition decode stays inline as a case statement.
// TESTING
//   1. Reset, then load_alu with flags_in=5'b00100 -> flags=5'b00100;
//      cond=1 -> cond_true=1; cond=2 -> cond_true=0; cond=15 -> cond_true=0.
//   2. flags=5'b00011 (S=1, O=1) -> cond 11 gives 0, cond 12 gives 1;
//      flags=5'b00010 -> cond 11 gives 1, cond 13 gives 1, cond 14 gives 0.
//   3. flags=5'b01000 with save+load_alu, flags_in=5'b00101 -> flags=5'b00101;
//      then restore -> flags=5'b01000, stack_empty=1.
//   4. Push STACK_DEPTH(4) times -> stack_full=1, stack_err=0; 5th push -> stack_err=1,
//      contents intact; 4 pops return the pushed values in reverse order; 5th pop -> flags held.
//   5. load_bus with bus_in=8'hFF and load_alu with flags_in=0 in the same cycle -> flags=5'h1F;
//      assert_bus=1 -> bus_out=8'h1F, bus_en=0.
//   6. Assert reset_n low mid-cycle with count=2 and stack_err=1 -> all outputs reach
//      reset values before the next edge.

Source files
------------

// File: rtl/flags_register_pkg.sv
// Shared ALU flag definitions: flag bit positions and branch condition codes.
// The ALU, control unit and flag register all import this package.
package flags_register_pkg;

    localparam int FLAG_W   = 5;
    localparam int LCARRY   = 4;
    localparam int ACARRY   = 3;
    localparam int ZERO     = 2;
    localparam int SIGN     = 1;
    localparam int OVERFLOW = 0;

    typedef enum logic [3:0] {
        CC_ALWAYS = 4'd0,
        CC_Z      = 4'd1,
        CC_NZ     = 4'd2,
        CC_C      = 4'd3,
        CC_NC     = 4'd4,
        CC_L      = 4'd5,
        CC_NL     = 4'd6,
        CC_S      = 4'd7,
        CC_NS     = 4'd8,
        CC_O      = 4'd9,
        CC_NO     = 4'd10,
        CC_LT     = 4'd11,
        CC_GE     = 4'd12,
        CC_LE     = 4'd13,
        CC_GT     = 4'd14,
        CC_NEVER  = 4'd15
    } cond_e;

endpackage

// File: rtl/flags_stack.sv
// Small LIFO of saved flag vectors for interrupt entry/exit.
// Simultaneous push and pop is a no-op; overflow/underflow set a sticky error.
module flags_stack
    import flags_register_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]     count;
    logic [FLAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~pop;
    assign do_pop  = pop & ~push;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign wr_idx  = AW'(count);
    assign rd_idx  = AW'(count - CW'(1));
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            err   <= 1'b0;
        end else if (do_push) begin
            if (full) err <= 1'b1;
            else      count <= count + CW'(1);
        end else if (do_pop) begin
            if (empty) err <= 1'b1;
            else       count <= count - CW'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !full) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/flags_register.sv
// ALU flag register with bus load/drive, save/restore LIFO and branch
// condition evaluation for the control unit.
module flags_register
    import flags_register_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              load_alu,
    input  logic              load_bus,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              assert_bus,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_en,
    input  logic              save,
    input  logic              restore,
    input  logic [3:0]        cond,
    output logic              cond_true,
    output logic [FLAG_W-1:0] flags,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    logic [FLAG_W-1:0] stk_dout;
    logic              pop_ok;
    logic              lt;

    flags_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset_n(reset_n),
        .push  (save),
        .pop   (restore),
        .din   (flags),
        .dout  (stk_dout),
        .empty (stack_empty),
        .full  (stack_full),
        .err   (stack_err)
    );

    // A pop that the stack would refuse falls through to the bus/ALU sources.
    assign pop_ok = restore & ~save & ~stack_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      flags <= '0;
        else if (pop_ok)   flags <= stk_dout;
        else if (load_bus) flags <= bus_in[FLAG_W-1:0];
        else if (load_alu) flags <= flags_in;
    end

    assign bus_out = WIDTH'(flags);
    assign bus_en  = ~assert_bus;

    generate
        if (WIDTH > FLAG_W) begin : g_unused
            logic unused_bus_hi;
            assign unused_bus_hi = ^bus_in[WIDTH-1:FLAG_W];
        end
    endgenerate

    assign lt = flags[SIGN] ^ flags[OVERFLOW];

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            CC_ALWAYS: cond_true = 1'b1;
            CC_Z:      cond_true = flags[ZERO];
            CC_NZ:     cond_true = ~flags[ZERO];
            CC_C:      cond_true = flags[ACARRY];
            CC_NC:     cond_true = ~flags[ACARRY];
            CC_L:      cond_true = flags[LCARRY];
            CC_NL:     cond_true = ~flags[LCARRY];
            CC_S:      cond_true = flags[SIGN];
            CC_NS:     cond_true = ~flags[SIGN];
            CC_O:      cond_true = flags[OVERFLOW];
            CC_NO:     cond_true = ~flags[OVERFLOW];
            CC_LT:     cond_true = lt;
            CC_GE:     cond_true = ~lt;
            CC_LE:     cond_true = lt | flags[ZERO];
            CC_GT:     cond_true = ~(lt | flags[ZERO]);
            CC_NEVER:  cond_true = 1'b0;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flags_register.sv
// Directed and randomized bench for flags_register against a queue-based model.
module tb_flags_register;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       flags_in;
    logic             load_alu, load_bus, assert_bus, save, restore;
    logic [WIDTH-1:0] bus_in, bus_out;
    logic             bus_en, cond_true, stack_empty, stack_full, stack_err;
    logic [3:0]       cond;
    logic [4:0]       flags;

    flags_register #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flags_in   (flags_in),
        .load_alu   (load_alu),
        .load_bus   (load_bus),
        .bus_in     (bus_in),
        .assert_bus (assert_bus),
        .bus_out    (bus_out),
        .bus_en     (bus_en),
        .save       (save),
        .restore    (restore),
        .cond       (cond),
        .cond_true  (cond_true),
        .flags      (flags),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    logic [4:0] mf;
    logic [4:0] mq[$];
    logic       merr;

    function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] f);
        logic l, cy, z, s, o, lt;
        logic [15:0] t;
        l = f[4]; cy = f[3]; z = f[2]; s = f[1]; o = f[0];
        lt = (s != o);
        t = {1'b0, !(lt || z), lt || z, !lt, lt, !o, o, !s, s, !l, l, !cy, cy, !z, z, 1'b1};
        return t[c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("flags",     32'(flags),       32'(mf));
        chk("bus_out",   32'(bus_out),     32'(mf));
        chk("bus_en",    32'(bus_en),      32'(!assert_bus));
        chk("cond_true", 32'(cond_true),   32'(cond_ref(cond, mf)));
        chk("empty",     32'(stack_empty), 32'(mq.size() == 0));
        chk("full",      32'(stack_full),  32'(mq.size() == DEPTH));
        chk("err",       32'(stack_err),   32'(merr));
    endtask

    // Drive one cycle of inputs, check the pre-edge view, advance model and clock.
    task automatic step(input logic la, input logic lb, input logic sv, input logic rs,
                        input logic ab, input logic [4:0] fin, input logic [WIDTH-1:0] bin,
                        input logic [3:0] cc);
        logic [4:0] nf;
        logic       popv;
        load_alu = la; load_bus = lb; save = sv; restore = rs;
        assert_bus = ab; flags_in = fin; bus_in = bin; cond = cc;
        #1;
        check_all();
        popv = rs && !sv && mq.size() > 0;
        if (popv)          nf = mq[$];
        else if (lb)       nf = bin[4:0];
        else if (la)       nf = fin;
        else               nf = mf;
        if (sv && !rs) begin
            if (mq.size() == DEPTH) merr = 1'b1;
            else                    mq.push_back(mf);
        end
        if (rs && !sv) begin
            if (mq.size() == 0) merr = 1'b1;
            else                void'(mq.pop_back());
        end
        mf = nf;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mf = '0;
        mq.delete();
        merr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        {load_alu, load_bus, save, restore, assert_bus} = '0;
        flags_in = '0; bus_in = '0; cond = 4'd14;
        model_reset();
        #3;
        check_all();
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: load_alu and simple conditions
        step(1, 0, 0, 0, 0, 5'b00100, 8'h00, 4'd0);
        chk("t1_flags", 32'(flags), 32'h04);
        step(0, 0, 0, 0, 0, 5'b0, 8'h00, 4'd1);
        chk("t1_c1", 32'(cond_true), 32'd1);
        cond = 4'd2;  #1 chk("t1_c2",  32'(cond_true), 32'd0);
        cond = 4'd15; #1 chk("t1_c15", 32'(cond_true), 32'd0);

        // 2: signed comparisons
        step(1, 0, 0, 0, 0, 5'b00011, 8'h00, 4'd11);
        chk("t2_c11a", 32'(cond_true), 32'd0);
        cond = 4'd12; #1 chk("t2_c12", 32'(cond_true), 32'd1);
        step(1, 0, 0, 0, 0, 5'b00010, 8'h00, 4'd11);
        chk("t2_c11b", 32'(cond_true), 32'd1);
        cond = 4'd13; #1 chk("t2_c13", 32'(cond_true), 32'd1);
        cond = 4'd14; #1 chk("t2_c14", 32'(cond_true), 32'd0);

        // 3: interrupt entry/exit
        step(1, 0, 0, 0, 0, 5'b01000, 8'h00, 4'd0);
        step(1, 0, 1, 0, 0, 5'b00101, 8'h00, 4'd0);
        chk("t3_flags", 32'(flags), 32'h05);
        step(0, 0, 0, 1, 0, 5'b0, 8'h00, 4'd0);
        chk("t3_restore", 32'(flags), 32'h08);
        chk("t3_empty", 32'(stack_empty), 32'd1);

        // 4: fill, overflow, drain, underflow
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 1, 0, 0, 5'(i), 8'h00, 4'd3);
        chk("t4_full", 32'(stack_full), 32'd1);
        chk("t4_err0", 32'(stack_err), 32'd0);
        step(1, 0, 1, 0, 0, 5'd5, 8'h00, 4'd3);
        chk("t4_err1", 32'(stack_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 5'd0, 8'h00, 4'd5);
        chk("t4_bottom", 32'(flags), 32'h08);
        step(0, 0, 0, 1, 0, 5'd0, 8'h00, 4'd5);
        chk("t4_held", 32'(flags), 32'h08);

        // 5: bus load beats ALU load; bus drive
        step(1, 1, 0, 0, 0, 5'd0, 8'hFF, 4'd0);
        chk("t5_flags", 32'(flags), 32'h1F);
        step(0, 0, 0, 0, 1, 5'd0, 8'h00, 4'd0);
        chk("t5_bus", 32'(bus_out), 32'h1F);
        chk("t5_en", 32'(bus_en), 32'd0);

        // 6: async reset mid-cycle with count=2, err=1
        step(1, 0, 1, 0, 0, 5'd3, 8'h00, 4'd0);
        step(1, 0, 1, 0, 0, 5'd7, 8'h00, 4'd0);
        load_alu = 1'b1; save = 1'b1; flags_in = 5'h11; cond = 4'd2;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 4'($urandom));
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
